// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and stop bits
// onto a registered serial line and polices the handshake with the external serializer.
`timescale 1ns/1ps
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  BUSY,
    output logic                  TX_OUT,
    output logic                  SYNC_ERR
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             par_en_q, par_en_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             sync_err_q, sync_err_d;
    logic             accept;
    logic             last_bit;

    // Odd parity is simply the even parity of the word inverted.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

    assign accept   = (state_q == S_IDLE) && DATA_VALID;
    assign last_bit = (cnt_q == LAST_CNT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        case (state_q)
            S_IDLE: begin
                if (DATA_VALID) begin
                    state_d  = S_START;
                    par_en_d = PAR_EN;
                    par_d    = parity_bit(P_DATA, PAR_TYP);
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                // Frame length is owned here; ser_done is only used for the sync check.
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ser_en     = (state_q == S_DATA);
        busy_d     = busy_q;
        sync_err_d = sync_err_q;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = ser_data;
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
        if (accept) begin
            busy_d     = 1'b1;
            sync_err_d = 1'b0;
        end
        if (state_q == S_STOP) begin
            busy_d = 1'b0;
        end
        // ser_done must be high on the last data bit and only there.
        if ((state_q == S_DATA) && (ser_done != last_bit)) begin
            sync_err_d = 1'b1;
        end
    end

    assign BUSY     = busy_q;
    assign TX_OUT   = tx_q;
    assign SYNC_ERR = sync_err_q;

endmodule
